mii_rx_deframer: RTL and testbench

- MAC-side MII receive deframer.
- Samples the PHY→MAC nibble stream (rx_dv/rx_er/rx_data), strips the preamble/SFD, assembles bytes, checks the Ethernet CRC-32 and strips the FCS.
- Emits payload bytes as a valid/last stream with a one-cycle per-frame status strobe.
- Sits between the MII pins and the RX frame buffer of the offload engine.

---
 rtl/mii_rx_deframer_if.sv | 31 +++
 rtl/mii_rx_deframer.sv | 210 +++++++++++++++++++++
 tb/tb_mii_rx_deframer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mii_rx_deframer_if.sv
// MII receive deframer bus bundle.
//   PHY side  : i_mii_rx_dv, i_mii_rx_er, i_mii_rx_data (nibble, low nibble of each byte first)
//   Stream    : o_data, o_valid, o_last (payload bytes, FCS stripped)
//   Status    : o_done strobe with o_len, o_crc_err, o_align_err, o_rx_er, o_len_err
// master = the deframer (samples MII, drives stream/status); slave = the consumer/PHY model.
interface mii_rx_deframer_if;
   logic        i_mii_rx_dv;
   logic        i_mii_rx_er;
   logic [3:0]  i_mii_rx_data;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        o_last;
   logic        o_done;
   logic [15:0] o_len;
   logic        o_crc_err;
   logic        o_align_err;
   logic        o_rx_er;
   logic        o_len_err;

   modport master (
      input  i_mii_rx_dv, i_mii_rx_er, i_mii_rx_data,
      output o_data, o_valid, o_last, o_done, o_len,
             o_crc_err, o_align_err, o_rx_er, o_len_err
   );

   modport slave (
      output i_mii_rx_dv, i_mii_rx_er, i_mii_rx_data,
      input  o_data, o_valid, o_last, o_done, o_len,
             o_crc_err, o_align_err, o_rx_er, o_len_err
   );
endinterface

// File: rtl/mii_rx_deframer.sv
// MAC-side MII receive deframer.
// Strips preamble/SFD, assembles bytes from nibbles, runs the reflected CRC-32 over
// every received byte (FCS included) and holds the last 4 bytes back in a 5-deep
// delay line so the FCS is never emitted. One o_done strobe per accepted frame.
// Ports:
//   i_rx_clk : MII receive clock
//   i_rstn   : asynchronous active-low reset
//   bus      : mii_rx_deframer_if.master (MII inputs, payload stream, frame status)
// Parameters:
//   MAX_LEN  : payload length above which o_len_err is flagged
//   MIN_PRE  : minimum 0x5 preamble nibbles before the SFD
module mii_rx_deframer #(
   parameter int MAX_LEN = 1518,
   parameter int MIN_PRE = 2
) (
   input  logic                  i_rx_clk,
   input  logic                  i_rstn,
   mii_rx_deframer_if.master     bus
);

   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   localparam logic [3:0]  MIN_PRE_C   = 4'(MIN_PRE);
   localparam logic [15:0] MAX_LEN_C   = 16'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

   state_t       state, state_nxt;
   logic [3:0]   pre_cnt;
   logic [3:0]   lo_nib;
   logic         phase_hi;
   logic [31:0]  crc;
   logic [16:0]  byte_cnt;
   logic         er_sticky;
   logic [7:0]   dly [0:4];

   logic [7:0]   data_p1;
   logic         vld_p1;
   logic         last_p1;
   logic         done_p1;
   logic [15:0]  len_p1;
   logic         crc_err_p1;
   logic         align_err_p1;
   logic         rx_er_p1;
   logic         len_err_p1;

   logic         dv, er;
   logic [3:0]   nib;
   logic         sfd_hit;
   logic         byte_done;
   logic         eof;
   logic [7:0]   cur_byte;
   logic [15:0]  len_c;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ b[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      return r;
   endfunction

   // Payload length = received bytes minus FCS, clamped to [0, 0xFFFF].
   function automatic logic [15:0] sat_len(input logic [16:0] cnt);
      logic [16:0] d;
      if (cnt < 17'd4)
         return 16'd0;
      d = cnt - 17'd4;
      if (d > 17'h0FFFF)
         return 16'hFFFF;
      return d[15:0];
   endfunction

   function automatic logic [16:0] sat_inc17(input logic [16:0] v);
      return (v == 17'h1FFFF) ? v : v + 17'd1;
   endfunction

   assign dv        = bus.i_mii_rx_dv;
   assign er        = bus.i_mii_rx_er;
   assign nib       = bus.i_mii_rx_data;
   assign sfd_hit   = (state == S_PRE) && dv && !er && (nib == 4'hD) && (pre_cnt >= MIN_PRE_C);
   assign byte_done = (state == S_DATA) && dv && phase_hi;
   assign eof       = (state == S_DATA) && !dv;
   assign cur_byte  = {nib, lo_nib};
   assign len_c     = sat_len(byte_cnt);

   always_ff @(posedge i_rx_clk or negedge i_rstn) begin
      if (!i_rstn)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (dv)
               state_nxt = (nib == 4'h5) ? S_PRE : S_DROP;
         end
         S_PRE: begin
            if (!dv)
               state_nxt = S_IDLE;
            else if (er)
               state_nxt = S_DROP;
            else if (nib == 4'h5)
               state_nxt = S_PRE;
            else if (sfd_hit)
               state_nxt = S_DATA;
            else
               state_nxt = S_DROP;
         end
         S_DATA: begin
            if (!dv)
               state_nxt = S_IDLE;
         end
         S_DROP: begin
            if (!dv)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_rx_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         pre_cnt      <= 4'd0;
         lo_nib       <= 4'd0;
         phase_hi     <= 1'b0;
         crc          <= 32'd0;
         byte_cnt     <= 17'd0;
         er_sticky    <= 1'b0;
         for (int i = 0; i < 5; i++)
            dly[i] <= 8'd0;
         data_p1      <= 8'd0;
         vld_p1       <= 1'b0;
         last_p1      <= 1'b0;
         done_p1      <= 1'b0;
         len_p1       <= 16'd0;
         crc_err_p1   <= 1'b0;
         align_err_p1 <= 1'b0;
         rx_er_p1     <= 1'b0;
         len_err_p1   <= 1'b0;
      end else begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         done_p1 <= 1'b0;

         if ((state == S_IDLE) && dv && (nib == 4'h5))
            pre_cnt <= 4'd1;
         else if ((state == S_PRE) && dv && !er && (nib == 4'h5) && (pre_cnt != 4'hF))
            pre_cnt <= pre_cnt + 4'd1;

         if (sfd_hit) begin
            phase_hi  <= 1'b0;
            crc       <= 32'hFFFFFFFF;
            byte_cnt  <= 17'd0;
            er_sticky <= 1'b0;
         end

         if ((state == S_DATA) && dv) begin
            if (er)
               er_sticky <= 1'b1;
            if (!phase_hi) begin
               lo_nib   <= nib;
               phase_hi <= 1'b1;
            end else begin
               phase_hi <= 1'b0;
               crc      <= crc_byte(crc, cur_byte);
               byte_cnt <= sat_inc17(byte_cnt);
               dly[0]   <= cur_byte;
               for (int i = 1; i < 5; i++)
                  dly[i] <= dly[i-1];
            end
         end

         // Output stage: a byte leaves the delay line only once five are held,
         // so the four FCS bytes are always still inside when the frame ends.
         if (byte_done && (byte_cnt >= 17'd5)) begin
            data_p1 <= dly[4];
            vld_p1  <= 1'b1;
         end

         if (eof) begin
            done_p1      <= 1'b1;
            len_p1       <= len_c;
            crc_err_p1   <= (crc != CRC_RESIDUE);
            align_err_p1 <= phase_hi;
            rx_er_p1     <= er_sticky;
            len_err_p1   <= (byte_cnt < 17'd5) || (len_c > MAX_LEN_C);
            if (byte_cnt >= 17'd5) begin
               data_p1 <= dly[4];
               vld_p1  <= 1'b1;
               last_p1 <= 1'b1;
            end
         end
      end
   end

   assign bus.o_data      = data_p1;
   assign bus.o_valid     = vld_p1;
   assign bus.o_last      = last_p1;
   assign bus.o_done      = done_p1;
   assign bus.o_len       = len_p1;
   assign bus.o_crc_err   = crc_err_p1;
   assign bus.o_align_err = align_err_p1;
   assign bus.o_rx_er     = rx_er_p1;
   assign bus.o_len_err   = len_err_p1;

endmodule

// File: tb/tb_mii_rx_deframer.sv
module tb_mii_rx_deframer;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   mii_rx_deframer_if bus ();

   mii_rx_deframer #(
      .MAX_LEN (1518),
      .MIN_PRE (2)
   ) dut (
      .i_rx_clk (clk),
      .i_rstn   (rstn),
      .bus      (bus)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct packed {
      logic [15:0] len;
      logic        crc_err;
      logic        align_err;
      logic        rx_er;
      logic        len_err;
   } st_t;

   beat_t      exp_q [$];
   st_t        got_st [$];
   logic [7:0] frm [$];
   int         checks   = 0;
   int         failures = 0;

   // Scoreboard: every payload beat is popped against the expected queue.
   always @(negedge clk) begin
      if (rstn) begin
         if (bus.o_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_valid got data=%h last=%b, required no beat", bus.o_data, bus.o_last);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               if ({bus.o_data, bus.o_last} !== {e.data, e.last}) begin
                  failures++;
                  $display("FAIL beat got data=%h last=%b, required data=%h last=%b",
                           bus.o_data, bus.o_last, e.data, e.last);
               end
            end
         end else if (bus.o_last) begin
            checks++;
            failures++;
            $display("FAIL last_without_valid got o_last=1, required 0");
         end
         if (bus.o_done)
            got_st.push_back({bus.o_len, bus.o_crc_err, bus.o_align_err, bus.o_rx_er, bus.o_len_err});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic make_frame(input int n, input int seed, input bit with_fcs);
      logic [31:0] c;
      logic [7:0]  b;
      frm.delete();
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         b = 8'(i + seed);
         frm.push_back(b);
         c = crc_upd(c, b);
      end
      if (with_fcs) begin
         c = ~c;
         for (int k = 0; k < 4; k++)
            frm.push_back(c[8*k +: 8]);
      end
   endtask

   function automatic bit residue_ok();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (frm[i]) c = crc_upd(c, frm[i]);
      return (c == 32'hDEBB20E3);
   endfunction

   task automatic expect_payload(input int n, input bit mark_last);
      beat_t e;
      for (int i = 0; i < n; i++) begin
         e.data = frm[i];
         e.last = mark_last && (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic send(input logic dv, input logic er, input logic [3:0] d);
      @(negedge clk);
      bus.i_mii_rx_dv   = dv;
      bus.i_mii_rx_er   = er;
      bus.i_mii_rx_data = d;
   endtask

   task automatic drive_frame(input int npre, input logic [3:0] sfd, input int nbytes,
                              input bit extra, input int er_nib, input bit gap);
      logic [7:0] b;
      for (int i = 0; i < npre; i++) send(1'b1, 1'b0, 4'h5);
      send(1'b1, 1'b0, sfd);
      for (int i = 0; i < nbytes; i++) begin
         b = frm[i];
         send(1'b1, (2*i) == er_nib, b[3:0]);
         send(1'b1, (2*i+1) == er_nib, b[7:4]);
      end
      if (extra) send(1'b1, 1'b0, 4'h3);
      if (gap)   send(1'b0, 1'b0, 4'h0);
   endtask

   task automatic get_status(output st_t s, output bit ok);
      ok = 1'b0;
      s  = '0;
      for (int k = 0; k < 20 && got_st.size() == 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (got_st.size() > 0) begin
         s  = got_st.pop_front();
         ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      bus.i_mii_rx_dv   = 1'b0;
      bus.i_mii_rx_er   = 1'b0;
      bus.i_mii_rx_data = 4'h0;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.o_data, bus.o_valid, bus.o_last, bus.o_done, bus.o_len, bus.o_crc_err,
           bus.o_align_err, bus.o_rx_er, bus.o_len_err} !== 33'd0) begin
         failures++;
         $display("FAIL reset_outputs got data=%h valid=%b done=%b len=%0d, required all 0",
                  bus.o_data, bus.o_valid, bus.o_done, bus.o_len);
      end
      rstn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good_frame();
      st_t s, e;
      bit  ok;
      make_frame(60, 0, 1'b1);
      expect_payload(60, 1'b1);
      drive_frame(15, 4'hD, 64, 1'b0, -1, 1'b1);
      get_status(s, ok);
      e = '{len: 16'd60, crc_err: 1'b0, align_err: 1'b0, rx_er: 1'b0, len_err: 1'b0};
      checks++;
      if (!ok || s !== e) begin
         failures++;
         $display("FAIL good_status got ok=%b st=%h, required %h", ok, s, e);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL good_beats got %0d missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_crc_err();
      st_t s, e;
      bit  ok;
      make_frame(60, 0, 1'b1);
      frm[10] = frm[10] ^ 8'h04;
      expect_payload(60, 1'b1);
      drive_frame(15, 4'hD, 64, 1'b0, -1, 1'b1);
      get_status(s, ok);
      e = '{len: 16'd60, crc_err: 1'b1, align_err: 1'b0, rx_er: 1'b0, len_err: 1'b0};
      checks++;
      if (!ok || s !== e) begin
         failures++;
         $display("FAIL crc_err_status got ok=%b st=%h, required %h", ok, s, e);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL crc_err_beats got %0d missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_runt();
      st_t s, e;
      bit  ok;
      make_frame(3, 8'h21, 1'b0);
      drive_frame(15, 4'hD, 3, 1'b0, -1, 1'b1);
      get_status(s, ok);
      e = '{len: 16'd0, crc_err: !residue_ok(), align_err: 1'b0, rx_er: 1'b0, len_err: 1'b1};
      checks++;
      if (!ok || s !== e) begin
         failures++;
         $display("FAIL runt_status got ok=%b st=%h, required %h", ok, s, e);
      end
   endtask

   task automatic test_align();
      st_t s, e;
      bit  ok;
      make_frame(60, 5, 1'b1);
      expect_payload(60, 1'b1);
      drive_frame(15, 4'hD, 64, 1'b1, -1, 1'b1);
      get_status(s, ok);
      e = '{len: 16'd60, crc_err: 1'b0, align_err: 1'b1, rx_er: 1'b0, len_err: 1'b0};
      checks++;
      if (!ok || s !== e) begin
         failures++;
         $display("FAIL align_status got ok=%b st=%h, required %h", ok, s, e);
      end
   endtask

   task automatic test_rx_er();
      st_t s, e;
      bit  ok;
      make_frame(60, 7, 1'b1);
      expect_payload(60, 1'b1);
      drive_frame(15, 4'hD, 64, 1'b0, 41, 1'b1);
      get_status(s, ok);
      e = '{len: 16'd60, crc_err: 1'b0, align_err: 1'b0, rx_er: 1'b1, len_err: 1'b0};
      checks++;
      if (!ok || s !== e) begin
         failures++;
         $display("FAIL rx_er_status got ok=%b st=%h, required %h", ok, s, e);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL rx_er_beats got %0d missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      st_t s, e;
      bit  ok;
      // bad SFD, then two good frames each separated by a single idle cycle
      drive_frame(15, 4'h7, 0, 1'b0, -1, 1'b1);
      make_frame(46, 3, 1'b1);
      expect_payload(46, 1'b1);
      drive_frame(15, 4'hD, 50, 1'b0, -1, 1'b1);
      make_frame(20, 9, 1'b1);
      expect_payload(20, 1'b1);
      drive_frame(7, 4'hD, 24, 1'b0, -1, 1'b1);
      get_status(s, ok);
      e = '{len: 16'd46, crc_err: 1'b0, align_err: 1'b0, rx_er: 1'b0, len_err: 1'b0};
      checks++;
      if (!ok || s !== e) begin
         failures++;
         $display("FAIL b2b_first_status got ok=%b st=%h, required %h", ok, s, e);
      end
      get_status(s, ok);
      e = '{len: 16'd20, crc_err: 1'b0, align_err: 1'b0, rx_er: 1'b0, len_err: 1'b0};
      checks++;
      if (!ok || s !== e) begin
         failures++;
         $display("FAIL b2b_second_status got ok=%b st=%h, required %h", ok, s, e);
      end
      checks++;
      if (got_st.size() != 0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_leftover got %0d status %0d beats, required 0 0", got_st.size(), exp_q.size());
         got_st.delete();
         exp_q.delete();
      end
   endtask

   task automatic test_min_preamble();
      st_t s, e;
      bit  ok;
      make_frame(20, 1, 1'b1);
      drive_frame(1, 4'hD, 24, 1'b0, -1, 1'b1);
      make_frame(20, 2, 1'b1);
      expect_payload(20, 1'b1);
      drive_frame(2, 4'hD, 24, 1'b0, -1, 1'b1);
      get_status(s, ok);
      e = '{len: 16'd20, crc_err: 1'b0, align_err: 1'b0, rx_er: 1'b0, len_err: 1'b0};
      checks++;
      if (!ok || s !== e) begin
         failures++;
         $display("FAIL min_pre_status got ok=%b st=%h, required %h", ok, s, e);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (got_st.size() != 0) begin
         failures++;
         $display("FAIL min_pre_extra_done got %0d, required 0", got_st.size());
         got_st.delete();
      end
   endtask

   task automatic test_overlong();
      st_t s, e;
      bit  ok;
      make_frame(1519, 0, 1'b1);
      expect_payload(1519, 1'b1);
      drive_frame(15, 4'hD, 1523, 1'b0, -1, 1'b1);
      get_status(s, ok);
      e = '{len: 16'd1519, crc_err: 1'b0, align_err: 1'b0, rx_er: 1'b0, len_err: 1'b1};
      checks++;
      if (!ok || s !== e) begin
         failures++;
         $display("FAIL overlong_status got ok=%b st=%h, required %h", ok, s, e);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL overlong_beats got %0d missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_midframe();
      st_t s, e;
      bit  ok;
      make_frame(60, 4, 1'b1);
      expect_payload(15, 1'b0);
      drive_frame(15, 4'hD, 20, 1'b0, -1, 1'b0);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      bus.i_mii_rx_dv = 1'b0;
      bus.i_mii_rx_data = 4'h0;
      #1;
      checks++;
      if ({bus.o_data, bus.o_valid, bus.o_last, bus.o_done, bus.o_len, bus.o_crc_err,
           bus.o_align_err, bus.o_rx_er, bus.o_len_err} !== 33'd0) begin
         failures++;
         $display("FAIL midframe_reset_outputs got data=%h valid=%b len=%0d, required all 0",
                  bus.o_data, bus.o_valid, bus.o_len);
      end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (got_st.size() != 0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL midframe_leftover got %0d status %0d beats, required 0 0", got_st.size(), exp_q.size());
         got_st.delete();
         exp_q.delete();
      end
      make_frame(60, 11, 1'b1);
      expect_payload(60, 1'b1);
      drive_frame(15, 4'hD, 64, 1'b0, -1, 1'b1);
      get_status(s, ok);
      e = '{len: 16'd60, crc_err: 1'b0, align_err: 1'b0, rx_er: 1'b0, len_err: 1'b0};
      checks++;
      if (!ok || s !== e) begin
         failures++;
         $display("FAIL after_reset_status got ok=%b st=%h, required %h", ok, s, e);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL after_reset_beats got %0d missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_crc_err();
      test_runt();
      test_align();
      test_rx_er();
      test_back_to_back();
      test_min_preamble();
      test_overlong();
      test_reset_midframe();
      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
